xcfi_retire_fifo: RTL and testbench
===================================

XCFI_RETIRE_FIFO -- requirements
Module: xcfi_retire_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered retirements; power of two, 2 to 16.
REQ-002 Parameter: XLEN, 32, data/PC width.
REQ-003 Port: clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: resetn  in  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  in  1  RVFI retirement strobe from the DUT wrapper; no back-pressure exists.
REQ-006 Port: in_order  in  64  RVFI retirement index.
REQ-007 Port: in_insn / in_pc_rdata / in_pc_wdata / in_rd_wdata  in  32 each  RVFI fields.
REQ-008 Port: in_trap  in  1; in_rd_addr  in  5  RVFI fields.
REQ-009 Port: out_valid  out  1  head entry present.
REQ-010 Port: out_ready  in  1  instruction checker consumes the head entry.
REQ-011 Port: out_order / out_insn / out_pc_rdata / out_pc_wdata / out_trap / out_rd_addr / out_rd_wdata  out  same widths  head entry fields.
REQ-012 Port: count  out  5  current occupancy, 0..DEPTH.
REQ-013 Port: overflow  out  1  sticky: a retirement was dropped.
REQ-014 Port: order_err  out  1  sticky: retirement order discontinuity (see Configuration).

Function
REQ-015 Push = in_valid && (count<DEPTH || pop); pop = out_valid && out_ready.
REQ-016 out_valid SHALL equal (count!=0); out_* SHALL present the oldest entry combinationally from storage.
REQ-017 Latency: an entry pushed at edge N SHALL be visible on out_* after edge N; no same-cycle bypass when empty.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH.
REQ-019 in_valid with count==DEPTH and no pop SHALL drop the entry, leave storage unchanged and set overflow on the next edge.
REQ-020 out_ready while empty SHALL be ignored; count never underflows.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be tracked separately so full and empty are unambiguous.
REQ-022 overflow and order_err SHALL remain set until reset.
REQ-023 When out_valid is 0, out_* data values are don't-care, but SHALL NOT be X after reset (storage reset to zero).

Reset
REQ-024 resetn low SHALL immediately clear pointers, count, overflow, order_err, order tracker, and storage; out_valid=0, all out_* = 0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; the first retirement after release is treated as the first ever.
REQ-026 Deassertion is synchronised externally; the block's first push is no earlier than the first edge with resetn high.

Configuration
REQ-027 Macro XCFI_ORDER_CHECK_EN defined: the block keeps a 64-bit expected-order register plus a seen-first flag; the first accepted-or-dropped retirement after reset loads expected=in_order+1; each later in_valid with in_order!=expected sets order_err, and expected then reloads from in_order+1.
REQ-028 Macro XCFI_ORDER_CHECK_EN undefined: no order tracking logic exists; order_err SHALL be tied to 0.
REQ-029 Order checking SHALL apply to every in_valid, including dropped ones, so overflow does not masquerade as an order error.

Verification
REQ-030 Reset, then in_valid one cycle with order=0, insn=0x00000013, out_ready=0 -> next cycle out_valid=1, count=1, out_insn=0x00000013.
REQ-031 DEPTH=4, five consecutive pushes (order 0..4), out_ready=0 -> count=4, overflow=1 after the fifth edge, out_order=0.
REQ-032 Full (count=4), in_valid with out_ready=1 the same cycle -> count stays 4, head advances to order 1, overflow remains 0.
REQ-033 Push orders 0,1,3 with XCFI_ORDER_CHECK_EN defined -> order_err=1 after the third edge; without the macro -> order_err stays 0.
REQ-034 Push 3 entries, assert resetn low mid-cycle -> out_valid=0, count=0 without waiting for a clock edge; first push after release with order=7 raises no order_err.
REQ-035 Continuous push and pop for 3×DEPTH cycles -> output order stream strictly matches input, pointers wrap with no loss or duplication.

Source files
------------

// File: rtl/xcfi_retire_fifo.sv
// rtl/xcfi_retire_fifo.sv - RVFI retirement buffer between DUT wrapper and instruction checker
// Optional order-continuity tracking is enabled by defining XCFI_ORDER_CHECK_EN.
module xcfi_retire_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    input  logic [63:0]     in_order,
    input  logic [XLEN-1:0] in_insn,
    input  logic [XLEN-1:0] in_pc_rdata,
    input  logic [XLEN-1:0] in_pc_wdata,
    input  logic [XLEN-1:0] in_rd_wdata,
    input  logic            in_trap,
    input  logic [4:0]      in_rd_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_order,
    output logic [XLEN-1:0] out_insn,
    output logic [XLEN-1:0] out_pc_rdata,
    output logic [XLEN-1:0] out_pc_wdata,
    output logic            out_trap,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_rd_wdata,
    output logic [4:0]      count,
    output logic            overflow,
    output logic            order_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] CNT_FULL = 5'(DEPTH);

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [XLEN-1:0] rd_wdata;
        logic            trap;
        logic [4:0]      rd_addr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop;

    always_comb begin
        pop        = (count_q != 5'd0) && out_ready;
        push       = in_valid && ((count_q < CNT_FULL) || pop);
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid && !push);
        if (push) begin
            mem_d[wptr_q] = '{order: in_order, insn: in_insn, pc_rdata: in_pc_rdata,
                              pc_wdata: in_pc_wdata, rd_wdata: in_rd_wdata,
                              trap: in_trap, rd_addr: in_rd_addr};
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        // Occupancy is kept apart from the pointers so full and empty never alias.
        if (push && !pop)      count_d = count_q + 5'd1;
        else if (pop && !push) count_d = count_q - 5'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef XCFI_ORDER_CHECK_EN
    logic [63:0] exp_q, exp_d;
    logic        seen_q, seen_d, order_err_q, order_err_d;

    // Every strobe is checked, dropped ones included, so an overflow never looks like a gap.
    always_comb begin
        exp_d       = exp_q;
        seen_d      = seen_q;
        order_err_d = order_err_q;
        if (in_valid) begin
            if (seen_q && (in_order != exp_q)) order_err_d = 1'b1;
            seen_d = 1'b1;
            exp_d  = in_order + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_q       <= '0;
            seen_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            seen_q      <= seen_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

    assign head         = mem_q[rptr_q];
    assign out_valid    = (count_q != 5'd0);
    assign out_order    = head.order;
    assign out_insn     = head.insn;
    assign out_pc_rdata = head.pc_rdata;
    assign out_pc_wdata = head.pc_wdata;
    assign out_trap     = head.trap;
    assign out_rd_addr  = head.rd_addr;
    assign out_rd_wdata = head.rd_wdata;
    assign count        = count_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_xcfi_retire_fifo.sv
// tb/tb_xcfi_retire_fifo.sv - scoreboard bench for xcfi_retire_fifo
module tb_xcfi_retire_fifo;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            resetn;
    logic            in_valid;
    logic [63:0]     in_order;
    logic [XLEN-1:0] in_insn, in_pc_rdata, in_pc_wdata, in_rd_wdata;
    logic            in_trap;
    logic [4:0]      in_rd_addr;
    logic            out_valid, out_ready;
    logic [63:0]     out_order;
    logic [XLEN-1:0] out_insn, out_pc_rdata, out_pc_wdata, out_rd_wdata;
    logic            out_trap;
    logic [4:0]      out_rd_addr, count;
    logic            overflow, order_err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_ord;
    logic        exp_oerr;

    always #5 clock = ~clock;

    xcfi_retire_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_order(in_order),
        .in_insn(in_insn), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
        .in_rd_wdata(in_rd_wdata), .in_trap(in_trap), .in_rd_addr(in_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_insn(out_insn), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_trap(out_trap), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .count(count), .overflow(overflow), .order_err(order_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] ord, input logic r);
        in_valid    = v;
        in_order    = ord;
        in_insn     = 32'h1000_0000 | ord[31:0];
        in_pc_rdata = {ord[29:0], 2'b00};
        in_pc_wdata = {ord[29:0], 2'b00} + 32'd4;
        in_rd_wdata = ~ord[31:0];
        in_trap     = ord[0];
        in_rd_addr  = ord[4:0];
        out_ready   = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 64'd0, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        sb.delete();
    endtask

    task automatic drain(input string name);
        int guard = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && guard < 2 * DEPTH) begin
            exp_ord = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out_order !== exp_ord) begin
                n_fail++;
                $display("FAIL %s_drain: valid=%b order=%0d want valid=1 order=%0d", name, out_valid, out_order, exp_ord);
            end
            tick();
            guard++;
        end
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_empty: valid=%b count=%0d want 0/0", name, out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 64'd0, 1'b0);
        resetn = 1'b0;
        #3;
        n_cmp++;
        if ({out_valid, count, overflow, order_err} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b count=%0d ovf=%b oerr=%b want all 0", out_valid, count, overflow, order_err);
        end
        n_cmp++;
        if (out_order !== 64'd0 || out_insn !== 32'd0 || out_rd_wdata !== 32'd0 || out_trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: order=%h insn=%h rdw=%h want 0", out_order, out_insn, out_rd_wdata);
        end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 64'd0, 1'b0);
        in_insn = 32'h0000_0013;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || count !== 5'd1 || out_insn !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL single_push: valid=%b count=%0d insn=%h want 1/1/00000013", out_valid, count, out_insn);
        end
        n_cmp++;
        if (out_pc_wdata !== 32'd4 || out_rd_wdata !== 32'hffff_ffff || out_rd_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL single_fields: pcw=%h rdw=%h rd=%0d want 4/ffffffff/0", out_pc_wdata, out_rd_wdata, out_rd_addr);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%b count=%0d want 0/0", out_valid, count);
        end
        tick();
        n_cmp++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL underflow: count=%0d want 0", count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b1, 64'(i), 1'b0);
            if (sb.size() < DEPTH) sb.push_back(64'(i));
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 5'(DEPTH) || overflow !== 1'b1 || out_order !== 64'd0) begin
            n_fail++;
            $display("FAIL overflow_full: count=%0d ovf=%b order=%0d want %0d/1/0", count, overflow, out_order, DEPTH);
        end
        drive(1'b1, 64'(DEPTH + 1), 1'b1);
        exp_ord = sb.pop_front();
        sb.push_back(64'(DEPTH + 1));
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (order_err !== 1'b0 || overflow !== 1'b1 || out_order !== 64'd1) begin
            n_fail++;
            $display("FAIL overflow_order: oerr=%b ovf=%b order=%0d want 0/1/1", order_err, overflow, out_order);
        end
        drain("overflow");
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 64'(i), 1'b0);
            sb.push_back(64'(i));
            tick();
        end
        drive(1'b1, 64'(DEPTH), 1'b1);
        exp_ord = sb.pop_front();
        sb.push_back(64'(DEPTH));
        n_cmp++;
        if (out_order !== exp_ord) begin
            n_fail++;
            $display("FAIL fullpp_head: order=%0d want %0d", out_order, exp_ord);
        end
        tick();
        drive(1'b0, 64'd0, 1'b0);
        n_cmp++;
        if (count !== 5'(DEPTH) || out_order !== 64'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_state: count=%0d order=%0d ovf=%b want %0d/1/0", count, out_order, overflow, DEPTH);
        end
        drain("fullpp");
    endtask

    task automatic test_order_gap();
        logic [63:0] ords [3];
        ords = '{64'd0, 64'd1, 64'd3};
        do_reset();
`ifdef XCFI_ORDER_CHECK_EN
        exp_oerr = 1'b1;
`else
        exp_oerr = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ords[i], 1'b0);
            sb.push_back(ords[i]);
            tick();
            if (i == 1) begin
                n_cmp++;
                if (order_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL order_contig: oerr=%b want 0", order_err);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (order_err !== exp_oerr) begin
            n_fail++;
            $display("FAIL order_gap: oerr=%b want %b", order_err, exp_oerr);
        end
        drain("order");
        n_cmp++;
        if (order_err !== exp_oerr) begin
            n_fail++;
            $display("FAIL order_sticky: oerr=%b want %b", order_err, exp_oerr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 10; i < 13; i++) begin
            drive(1'b1, 64'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 5'd0 || out_order !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d order=%0d want 0/0/0", out_valid, count, out_order);
        end
        tick();
        resetn = 1'b1;
        sb.delete();
        drive(1'b1, 64'd7, 1'b0);
        sb.push_back(64'd7);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 5'd1 || out_order !== 64'd7 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: count=%0d order=%0d oerr=%b want 1/7/0", count, out_order, order_err);
        end
        drain("async");
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 64'd100, 1'b0);
        sb.push_back(64'd100);
        tick();
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            drive(1'b1, 64'(100 + i), 1'b1);
            exp_ord = sb.pop_front();
            sb.push_back(64'(100 + i));
            n_cmp++;
            if (out_valid !== 1'b1 || out_order !== exp_ord || out_insn !== (32'h1000_0000 | exp_ord[31:0])) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b order=%0d insn=%h want order=%0d", i, out_valid, out_order, out_insn, exp_ord);
            end
            tick();
            n_cmp++;
            if (count !== 5'd1) begin
                n_fail++;
                $display("FAIL stream_count_%0d: count=%0d want 1", i, count);
            end
        end
        drain("stream");
        n_cmp++;
        if (overflow !== 1'b0 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_flags: ovf=%b oerr=%b want 0/0", overflow, order_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_order_gap();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
